// File: rtl/connect4_pin_rx.sv
// connect4_pin_rx: receiver for the 8-pin connect4 board link.
// Synchronizes pin_in, detects row strobes, assembles four 4-bit rows into a
// shadow board and commits it to gameboard_rx once all rows arrive in order.
// Optional build macro CONNECT4_RX_TIMEOUT_EN adds an inter-row timeout.
//
// state  | meaning
// IDLE   | waiting for a row-0 strobe with the frame-start pin set
// RECV   | frame in progress, waiting for row exp_q
// COMMIT | one cycle: shadow copied to gameboard_rx, frame_done pulsed
module connect4_pin_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  pin_in,
    output logic [15:0] gameboard_rx,
    output logic        frame_done,
    output logic        frame_err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, RECV, COMMIT} state_t;

    if (SYNC_STAGES < 2 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("connect4_pin_rx: SYNC_STAGES must be >= 2 and TIMEOUT_CYC >= 1");
    end

    logic [7:0]             sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] valid_q;
    logic                   strobe_prev_q;

    state_t      state_q;
    logic [15:0] shadow_q;
    logic [1:0]  exp_q;
    logic [15:0] gameboard_q;
    logic        frame_done_q;
    logic        frame_err_q;
    logic        busy_q;

    logic [7:0] pins_s;
    logic       sample_valid;
    logic       accept;
    logic       acc_start;
    logic [1:0] acc_idx;
    logic [3:0] acc_data;
    logic       acc_frame_start;
    logic       timeout_hit;

    assign pins_s          = sync_q[SYNC_STAGES-1];
    assign sample_valid    = valid_q[SYNC_STAGES-1];
    assign acc_start       = pins_s[7];
    assign acc_idx         = pins_s[5:4];
    assign acc_data        = pins_s[3:0];
    assign accept          = sample_valid & pins_s[6] & ~strobe_prev_q;
    assign acc_frame_start = acc_start && (acc_idx == 2'd0);

    // Pin synchronizer and strobe edge detector. valid_q marks stages that
    // hold post-reset samples; until the chain is full the previous strobe is
    // treated as high, so a strobe already asserted at reset release is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            valid_q       <= '0;
            strobe_prev_q <= 1'b0;
        end else begin
            sync_q[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            valid_q       <= {valid_q[SYNC_STAGES-2:0], 1'b1};
            strobe_prev_q <= sample_valid ? pins_s[6] : 1'b1;
        end
    end

`ifdef CONNECT4_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt_q;

    // Inter-row timer: cleared by any accept, counts in RECV, saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else if (accept) begin
            to_cnt_q <= '0;
        end else if (state_q == RECV && to_cnt_q != TW'(TIMEOUT_CYC)) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    // Fires on the cycle the counter steps onto TIMEOUT_CYC.
    assign timeout_hit = (state_q == RECV) && !accept && (to_cnt_q == TW'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Frame FSM with registered outputs; COMMIT also services a new frame start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            exp_q        <= 2'd0;
            gameboard_q  <= '0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                IDLE, COMMIT: begin
                    if (state_q == COMMIT) begin
                        gameboard_q  <= shadow_q;
                        frame_done_q <= 1'b1;
                    end
                    if (accept && acc_frame_start) begin
                        shadow_q <= {12'h000, acc_data};
                        exp_q    <= 2'd1;
                        state_q  <= RECV;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                    end
                end
                RECV: begin
                    if (accept) begin
                        if (acc_frame_start) begin
                            frame_err_q <= 1'b1;
                            shadow_q    <= {12'h000, acc_data};
                            exp_q       <= 2'd1;
                            busy_q      <= 1'b1;
                        end else if (!acc_start && acc_idx == exp_q) begin
                            shadow_q[{acc_idx, 2'b00} +: 4] <= acc_data;
                            exp_q <= exp_q + 2'd1;
                            if (acc_idx == 2'd3) begin
                                state_q <= COMMIT;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            shadow_q    <= '0;
                            exp_q       <= 2'd0;
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                        end
                    end else if (timeout_hit) begin
                        frame_err_q <= 1'b1;
                        shadow_q    <= '0;
                        exp_q       <= 2'd0;
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gameboard_rx = gameboard_q;
    assign frame_done   = frame_done_q;
    assign frame_err    = frame_err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_connect4_pin_rx.sv
// Directed bench for connect4_pin_rx: board words expected from complete
// frames are queued as rows are sent and checked when frame_done appears.
module tb_connect4_pin_rx;

    localparam int SYNC = 2;
    localparam int TO   = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  pin_in = 8'h00;
    logic [15:0] gameboard_rx;
    logic        frame_done;
    logic        frame_err;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int err_seen = 0;
    int done_seen = 0;
    logic [15:0] sb [$];

    connect4_pin_rx #(.SYNC_STAGES(SYNC), .TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .pin_in       (pin_in),
        .gameboard_rx (gameboard_rx),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic send_row(input logic start, input logic [1:0] idx, input logic [3:0] data);
        @(posedge clk); #1 pin_in = {start, 1'b1, idx, data};
        repeat (4) @(posedge clk);
        #1 pin_in = 8'h00;
        repeat (4) @(posedge clk);
    endtask

    // Scoreboard monitor: pulse accounting and board comparison on frame_done.
    always @(negedge clk) begin
        logic [15:0] exp_b;
        if (frame_err) err_seen++;
        if (frame_done) begin
            done_seen++;
            chk("done_err_excl", 32'(frame_err), 32'd0);
            if (sb.size() > 0) begin
                exp_b = sb.pop_front();
                chk("sb_board", 32'(gameboard_rx), 32'(exp_b));
            end else begin
                chk("sb_unexpected_done", 32'(sb.size()), 32'd1);
            end
        end
    end

    initial begin
        int e0;
        int d0;

        // Reset held with random pin activity.
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1 pin_in = 8'($urandom);
        end
        @(negedge clk);
        chk("rst_board", 32'(gameboard_rx), 32'h0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Valid frame-start strobe already high at reset release: not an edge.
        pin_in = 8'hC1;
        @(negedge clk); reset = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("held_strobe_busy", 32'(busy), 32'd0);
        pin_in = 8'h00;
        repeat (4) @(posedge clk);

        // Normal frame 1,3,7,F with commit latency check on row 3.
        sb.push_back(16'hF731);
        send_row(1'b1, 2'd0, 4'h1);
        send_row(1'b0, 2'd1, 4'h3);
        send_row(1'b0, 2'd2, 4'h7);
        @(negedge clk);
        chk("frame_busy_mid", 32'(busy), 32'd1);
        @(posedge clk); #1 pin_in = {1'b0, 1'b1, 2'd3, 4'hF};
        repeat (SYNC + 1) @(posedge clk);
        @(negedge clk);
        chk("lat_board_early", 32'(gameboard_rx), 32'h0);
        chk("lat_done_early", 32'(frame_done), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_board", 32'(gameboard_rx), 32'hF731);
        chk("lat_done", 32'(frame_done), 32'd1);
        chk("lat_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 pin_in = 8'h00;
        repeat (4) @(posedge clk);
        chk("done_count_1", 32'(done_seen), 32'd1);

        // Out-of-order row: error, board unchanged; then frame 8,4,2,1.
        e0 = err_seen;
        send_row(1'b1, 2'd0, 4'h5);
        send_row(1'b0, 2'd2, 4'h6);
        @(negedge clk);
        chk("ooo_err", 32'(err_seen), 32'(e0 + 1));
        chk("ooo_busy", 32'(busy), 32'd0);
        chk("ooo_board", 32'(gameboard_rx), 32'hF731);
        sb.push_back(16'h1248);
        send_row(1'b1, 2'd0, 4'h8);
        send_row(1'b0, 2'd1, 4'h4);
        send_row(1'b0, 2'd2, 4'h2);
        send_row(1'b0, 2'd3, 4'h1);
        @(negedge clk);
        chk("ooo_next_board", 32'(gameboard_rx), 32'h1248);

        // Restart mid-frame: new row 0 replaces the abandoned frame.
        e0 = err_seen;
        send_row(1'b1, 2'd0, 4'hA);
        send_row(1'b0, 2'd1, 4'hB);
        send_row(1'b1, 2'd0, 4'h5);
        @(negedge clk);
        chk("restart_err", 32'(err_seen), 32'(e0 + 1));
        chk("restart_busy", 32'(busy), 32'd1);
        sb.push_back(16'h9765);
        send_row(1'b0, 2'd1, 4'h6);
        send_row(1'b0, 2'd2, 4'h7);
        send_row(1'b0, 2'd3, 4'h9);
        @(negedge clk);
        chk("restart_board", 32'(gameboard_rx), 32'h9765);

        // Reset mid-frame, then orphan rows 1..3 must be ignored.
        send_row(1'b1, 2'd0, 4'h3);
        send_row(1'b0, 2'd1, 4'h3);
        send_row(1'b0, 2'd2, 4'h3);
        @(negedge clk); reset = 1'b1;
        #2;
        chk("midrst_board", 32'(gameboard_rx), 32'h0);
        chk("midrst_done", 32'(frame_done), 32'd0);
        chk("midrst_err", 32'(frame_err), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk); reset = 1'b0;
        d0 = done_seen;
        e0 = err_seen;
        send_row(1'b0, 2'd1, 4'hC);
        send_row(1'b0, 2'd2, 4'hC);
        send_row(1'b0, 2'd3, 4'hC);
        @(negedge clk);
        chk("orphan_busy", 32'(busy), 32'd0);
        chk("orphan_done", 32'(done_seen), 32'(d0));
        chk("orphan_err", 32'(err_seen), 32'(e0));
        chk("orphan_board", 32'(gameboard_rx), 32'h0);

        // Row 0 followed by silence: timeout only when the feature is built.
        e0 = err_seen;
        @(posedge clk); #1 pin_in = 8'hC3;
        for (int i = 0; i < SYNC + TO; i++) begin
            @(posedge clk);
            if (i == 3) begin #1 pin_in = 8'h00; end
        end
        @(negedge clk);
        chk("to_pre_err", 32'(frame_err), 32'd0);
        chk("to_pre_busy", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
`ifdef CONNECT4_RX_TIMEOUT_EN
        chk("to_err", 32'(frame_err), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
`else
        chk("to_err", 32'(frame_err), 32'd0);
        chk("to_busy", 32'(busy), 32'd1);
`endif
        repeat (10) @(posedge clk);
        @(negedge clk);
`ifdef CONNECT4_RX_TIMEOUT_EN
        chk("to_err_count", 32'(err_seen), 32'(e0 + 1));
        chk("to_busy_late", 32'(busy), 32'd0);
`else
        chk("to_err_count", 32'(err_seen), 32'(e0));
        chk("to_busy_late", 32'(busy), 32'd1);
`endif
        chk("to_board", 32'(gameboard_rx), 32'h0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("done_total", 32'(done_seen), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
